c17_fault_sweep_ctrl: RTL and testbench

- Sequential controller that runs an exhaustive single-stuck-at fault campaign on the c17 fault-injectable benchmark.
- Drives a shared 5-bit input vector to two c17 instances:
  - golden instance, opcode tied to 0 (fault-free);
  - faulty instance, opcode driven by this block.
- Steps through every fault code and every vector, compares the two instances' outputs, and streams one result per fault over a valid/ready interface.
- Reports the total detected-fault count at the end of the campaign.

---
 rtl/c17_fault_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_c17_fault_sweep_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_fault_sweep_ctrl.sv
// Exhaustive single-stuck-at campaign controller for c17: sweeps every fault code and vector,
// compares golden vs faulty outputs and streams one result per fault over valid/ready.
`timescale 1ns/1ps
module c17_fault_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter bit          DROP   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] vec_o,
  output logic [5:0] opcode_o,
  input  logic [1:0] good_i,
  input  logic [1:0] flt_i,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_code,
  output logic       res_det,
  output logic [4:0] res_vec,
  output logic       done,
  output logic [5:0] det_count
);

  localparam logic [5:0] LastFault  = 6'd33;
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StReport, StDone} state_e;

  state_e     state_q, state_d;
  logic [5:0] fi_q, fi_d;
  logic [4:0] v_q, v_d;
  logic [3:0] sc_q, sc_d;
  logic       det_q, det_d;
  logic [4:0] dvec_q, dvec_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] opc_q, opc_d;
  logic [4:0] vec_q, vec_d;
  logic       new_det;

  // Fault table: four contiguous code ranges packed into indices 0..33.
  function automatic logic [5:0] fault_code(input logic [5:0] idx);
    if (idx < 6'd6)       return idx + 6'd2;
    else if (idx < 6'd18) return idx + 6'd6;
    else if (idx < 6'd24) return idx + 6'd10;
    else                  return idx + 6'd14;
  endfunction

  always_comb begin
    state_d = state_q;
    fi_d    = fi_q;
    v_d     = v_q;
    sc_d    = sc_q;
    det_d   = det_q;
    dvec_d  = dvec_q;
    cnt_d   = cnt_q;
    new_det = 1'b0;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      det_d   = 1'b0;
      dvec_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d = StRun;
            fi_d    = '0;
            v_d     = '0;
            sc_d    = '0;
            det_d   = 1'b0;
            dvec_d  = '0;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (sc_q == SettleLast) begin
            new_det = (good_i != flt_i) && !det_q;
            if (new_det) begin
              det_d  = 1'b1;
              dvec_d = v_q;
            end
            if (new_det && DROP) begin
              state_d = StReport;
            end else if (v_q == 5'd31) begin
              state_d = StReport;
            end else begin
              v_d  = v_q + 5'd1;
              sc_d = '0;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        StReport: begin
          if (res_ready) begin
            cnt_d  = cnt_q + {5'd0, det_q};
            det_d  = 1'b0;
            dvec_d = '0;
            if (fi_q == LastFault) begin
              state_d = StDone;
            end else begin
              state_d = StRun;
              fi_d    = fi_q + 6'd1;
              v_d     = '0;
              sc_d    = '0;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // Drive the instances from next-state so each RUN cycle already sees its own vector.
    opc_d = (state_d == StRun) ? fault_code(fi_d) : 6'd0;
    vec_d = (state_d == StRun) ? v_d : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fi_q    <= '0;
      v_q     <= '0;
      sc_q    <= '0;
      det_q   <= 1'b0;
      dvec_q  <= '0;
      cnt_q   <= '0;
      opc_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      fi_q    <= fi_d;
      v_q     <= v_d;
      sc_q    <= sc_d;
      det_q   <= det_d;
      dvec_q  <= dvec_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    res_valid = (state_q == StReport);
    done      = (state_q == StDone);
    res_code  = res_valid ? fault_code(fi_q) : 6'd0;
    res_det   = res_valid & det_q;
    res_vec   = res_valid ? dvec_q : 5'd0;
    det_count = cnt_q;
    opcode_o  = opc_q;
    vec_o     = vec_q;
  end

endmodule

// File: tb/tb_c17_fault_sweep_ctrl.sv
// Bench for c17_fault_sweep_ctrl: three configurations, each with golden/faulty c17 models,
// results scoreboarded against a per-fault exhaustive reference model.
`timescale 1ns/1ps
module tb_c17_fault_sweep_ctrl;
  localparam int N = 3;

  typedef struct packed {
    logic [5:0] code;
    logic       det;
    logic [4:0] vec;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start [N];
  logic       abort [N];
  logic       rdy   [N];
  logic [4:0] vec   [N];
  logic [5:0] opc   [N];
  logic [1:0] good  [N];
  logic [1:0] flt   [N];
  logic       busy  [N];
  logic       rv    [N];
  logic [5:0] rcode [N];
  logic       rdet  [N];
  logic [4:0] rvec  [N];
  logic       done  [N];
  logic [5:0] dcnt  [N];

  int   rdy_mode [N];
  bit   tim_en   [N];
  int   exp_cnt  [N];
  int   done_cnt [N];
  int   cyc      [N];
  bit   hold_pend[N];
  res_t held     [N];
  res_t exp_q    [N][$];
  int   tbl[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Gate-level c17 with every stem and fanout branch injectable; code = 2*site + stuck value.
  function automatic logic [1:0] c17(input logic [4:0] v, input logic [5:0] code);
    logic [4:0] s;
    logic sa, n1, n2, n3, n6, n7, n3a, n3b, n10, n11, n11a, n11b;
    logic n16, n19, n16a, n16b, n22, n23;
    s = code[5:1];
    sa = code[0];
    n1 = (s == 5'd1) ? sa : v[4];
    n2 = (s == 5'd2) ? sa : v[3];
    n3 = (s == 5'd3) ? sa : v[2];
    n6 = (s == 5'd6) ? sa : v[1];
    n7 = (s == 5'd7) ? sa : v[0];
    n3a = (s == 5'd8) ? sa : n3;
    n3b = (s == 5'd9) ? sa : n3;
    n10 = (s == 5'd10) ? sa : ~(n1 & n3a);
    n11 = (s == 5'd11) ? sa : ~(n3b & n6);
    n11a = (s == 5'd14) ? sa : n11;
    n11b = (s == 5'd15) ? sa : n11;
    n16 = (s == 5'd16) ? sa : ~(n2 & n11a);
    n19 = (s == 5'd19) ? sa : ~(n11b & n7);
    n16a = (s == 5'd20) ? sa : n16;
    n16b = (s == 5'd21) ? sa : n16;
    n22 = (s == 5'd22) ? sa : ~(n10 & n16a);
    n23 = (s == 5'd23) ? sa : ~(n16b & n19);
    return {n22, n23};
  endfunction

  function automatic res_t ref_result(input int code);
    res_t r;
    r = '0;
    r.code = 6'(code);
    for (int v = 0; v < 32; v++)
      if (!r.det && (c17(5'(v), 6'd0) != c17(5'(v), 6'(code)))) begin
        r.det = 1'b1;
        r.vec = 5'(v);
      end
    return r;
  endfunction

  function automatic int settle_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign good[g] = c17(vec[g], 6'd0);
    assign flt[g]  = c17(vec[g], opc[g]);
    c17_fault_sweep_ctrl #(
      .SETTLE(g == 2 ? 3 : 1),
      .DROP  (g == 0 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .abort    (abort[g]),
      .vec_o    (vec[g]),
      .opcode_o (opc[g]),
      .good_i   (good[g]),
      .flt_i    (flt[g]),
      .busy     (busy[g]),
      .res_valid(rv[g]),
      .res_ready(rdy[g]),
      .res_code (rcode[g]),
      .res_det  (rdet[g]),
      .res_vec  (rvec[g]),
      .done     (done[g]),
      .det_count(dcnt[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer ready: 0 = held low, 1 = always high, 2 = random.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++)
      rdy[k] = (rdy_mode[k] == 0) ? 1'b0 : (rdy_mode[k] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pops, hold stability, timing model and end-of-campaign count.
  always @(negedge clk) begin
    res_t e;
    int s, per, f, p;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        hold_pend[k] = 1'b0;
        cyc[k] = 0;
      end else begin
        cyc[k] = busy[k] ? cyc[k] + 1 : 0;
        if (hold_pend[k])
          check("hold_stable", {rv[k], rcode[k], rdet[k], rvec[k]}, {1'b1, held[k]});
        hold_pend[k] = rv[k] && !rdy[k];
        held[k] = {rcode[k], rdet[k], rvec[k]};
        if (rv[k]) begin
          check("report_idle_drive", {opc[k], vec[k]}, 64'd0);
          if (rdy[k]) begin
            checks++;
            if (exp_q[k].size() == 0) begin
              failures++;
              $display("FAIL unexpected_result: inst %0d got code %0d, none expected", k, rcode[k]);
            end else begin
              e = exp_q[k].pop_front();
              checks--;
              check("result", {rcode[k], rdet[k], rvec[k]}, e);
            end
          end
        end
        s = settle_of(k);
        per = 32 * s + 1;
        if (tim_en[k] && busy[k] && cyc[k] <= 34 * per) begin
          f = (cyc[k] - 1) / per;
          p = (cyc[k] - 1) % per;
          if (p < 32 * s)
            check("run_timing", {rv[k], opc[k], vec[k]}, {1'b0, 6'(tbl[f]), 5'(p / s)});
          else
            check("report_timing", {rv[k], rcode[k], opc[k], vec[k]}, {1'b1, 6'(tbl[f]), 11'd0});
        end
        if (done[k]) begin
          done_cnt[k]++;
          check("det_count_at_done", dcnt[k], exp_cnt[k]);
          check("results_left", exp_q[k].size(), 0);
          // DONE is entered 34*per edges after start accept; first RUN cycle counts as 1.
          if (tim_en[k]) check("done_cycle", cyc[k], 34 * per + 1);
        end
      end
    end
  end

  task automatic prime(input int k);
    res_t r;
    exp_cnt[k] = 0;
    foreach (tbl[i]) begin
      r = ref_result(tbl[i]);
      exp_q[k].push_back(r);
      exp_cnt[k] += int'(r.det);
    end
    start[k] = 1'b1;
  endtask

  task automatic wait_valid(input int k, input int budget);
    int n = 0;
    while (!rv[k] && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", rv[k], 1);
  endtask

  task automatic wait_done(input int k, input int target, input int budget);
    int n = 0;
    while (done_cnt[k] < target && n < budget) begin
      tick();
      n++;
    end
    check("campaign_done", done_cnt[k] >= target, 1);
  endtask

  task automatic check_reset(input int k, input string name);
    check(name, {vec[k], opc[k], busy[k], rv[k], rcode[k], rdet[k], rvec[k], done[k], dcnt[k]},
          64'd0);
  endtask

  initial begin
    int exp10, n;
    for (int c = 2; c <= 47; c++)
      if (c <= 7 || (c >= 12 && c <= 23) || (c >= 28 && c <= 33) || c >= 38) tbl.push_back(c);
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      rdy[k] = 1'b0;
      rdy_mode[k] = 1;
      tim_en[k] = 1'b0;
      done_cnt[k] = 0;
      cyc[k] = 0;
      hold_pend[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #11;
    for (int k = 0; k < N; k++) check_reset(k, "reset_outputs");
    tick();
    rst_n = 1'b1;
    tick();

    // All three configurations in parallel; inst0 stalls its first result.
    rdy_mode[0] = 0;
    tim_en[1] = 1'b1;
    tim_en[2] = 1'b1;
    for (int k = 0; k < N; k++) prime(k);
    tick();
    for (int k = 0; k < N; k++) start[k] = 1'b0;
    wait_valid(0, 100);
    for (int i = 0; i < 5; i++) begin
      check("stall_fields", {rcode[0], rdet[0], rvec[0], opc[0]}, {6'd2, 1'b1, 5'd20, 6'd0});
      tick();
    end
    rdy_mode[0] = 2;
    repeat (3) tick();
    start[0] = 1'b1;  // must be ignored while busy
    tick();
    start[0] = 1'b0;
    wait_done(0, 1, 5000);
    wait_done(1, 1, 5000);
    wait_done(2, 1, 5000);
    repeat (3) tick();
    for (int k = 0; k < N; k++) check("done_pulses", done_cnt[k], 1);
    tim_en[1] = 1'b0;
    tim_en[2] = 1'b0;

    // Abort during RUN of fault index 10.
    rdy_mode[0] = 1;
    exp10 = 0;
    for (int i = 0; i < 10; i++) exp10 += int'(ref_result(tbl[i]).det);
    prime(0);
    tick();
    start[0] = 1'b0;
    n = 0;
    while (opc[0] != 6'(tbl[10]) && n < 2000) begin
      tick();
      n++;
    end
    check("reach_fault10", opc[0], tbl[10]);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_idle", {busy[0], rv[0], opc[0], vec[0], done[0]}, 64'd0);
    check("abort_det_count", dcnt[0], exp10);
    check("abort_pending", exp_q[0].size(), 24);
    exp_q[0].delete();
    repeat (5) tick();
    check("no_done_after_abort", done_cnt[0], 1);

    // start and abort together in IDLE: abort wins.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_abort_idle", busy[0], 0);

    // Asynchronous reset while a result is pending, then a full rerun.
    rdy_mode[0] = 0;
    prime(0);
    tick();
    start[0] = 1'b0;
    wait_valid(0, 100);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0, "async_reset");
    exp_q[0].delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("no_autorestart", busy[0], 0);
    rdy_mode[0] = 2;
    prime(0);
    tick();
    start[0] = 1'b0;
    wait_done(0, 2, 5000);
    repeat (3) tick();
    check("done_pulses_rerun", done_cnt[0], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "timeout");
  end

endmodule
